// File: rtl/tpu_tile_sequencer_if.sv
// Host, memory and array-side signals of the tile sequencer.
// The sequencer is the slave; the host/memories side is the master.
interface tpu_tile_sequencer_if #(
   parameter int unsigned ADDRESSSIZE = 10,
   parameter int unsigned WADDR_BW    = 2
);
   logic                   start;
   logic [ADDRESSSIZE-1:0] cfg_ub_base;
   logic [ADDRESSSIZE-1:0] cfg_res_base;
   logic [ADDRESSSIZE:0]   cfg_rows;
   logic [WADDR_BW-1:0]    cfg_wsel;
   logic                   cfg_wreuse;
   logic                   busy;
   logic                   done;
   logic                   err;
   logic [WADDR_BW-1:0]    w_addr;
   logic                   we_rl;
   logic                   ub_re;
   logic [ADDRESSSIZE-1:0] ub_addr;
   logic                   res_we;
   logic [ADDRESSSIZE-1:0] res_addr;

   modport master (
      output start, cfg_ub_base, cfg_res_base, cfg_rows, cfg_wsel, cfg_wreuse,
      input  busy, done, err, w_addr, we_rl, ub_re, ub_addr, res_we, res_addr
   );

   modport slave (
      input  start, cfg_ub_base, cfg_res_base, cfg_rows, cfg_wsel, cfg_wreuse,
      output busy, done, err, w_addr, we_rl, ub_re, ub_addr, res_we, res_addr
   );
endinterface

// File: rtl/tpu_tile_sequencer.sv
// Control FSM for one systolic tile pass: weight load, row streaming,
// latency-aligned result writes and a completion pulse.
module tpu_tile_sequencer #(
   parameter int unsigned MATRIX_SIZE = 32,
   parameter int unsigned ADDRESSSIZE = 10,
   parameter int unsigned WADDR_BW    = 2,
   parameter int unsigned RESULT_LAT  = 3 * MATRIX_SIZE - 1
) (
   input  logic                 clk,
   input  logic                 rstn,
   tpu_tile_sequencer_if.slave  bus
);

   localparam int unsigned RW = ADDRESSSIZE + 1;

   typedef enum logic [2:0] {IDLE, WADR, WLD, STREAM, DRAIN, DONE} state_e;

   state_e                 state, state_d;
   logic                   wvalid;
   logic                   accept, reject;
   logic [RW-1:0]          rows_left;
   logic [ADDRESSSIZE-1:0] res_next;
   logic [RESULT_LAT-1:0]  vsr, vsr_d;

   // Row-valid pipeline mirroring the array latency; its tap is res_we.
   assign vsr_d      = (vsr << 1) | RESULT_LAT'(bus.ub_re);
   assign bus.res_we = vsr[RESULT_LAT-1];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= IDLE;
      else       state <= state_d;
   end

   always_comb begin
      state_d = state;
      accept  = 1'b0;
      reject  = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               if (bus.cfg_rows != '0 && !(bus.cfg_wreuse && !wvalid)) begin
                  accept  = 1'b1;
                  state_d = bus.cfg_wreuse ? STREAM : WADR;
               end else begin
                  reject = 1'b1;
               end
            end
         end
         WADR:    state_d = WLD;
         WLD:     state_d = STREAM;
         STREAM:  if (rows_left == RW'(1)) state_d = DRAIN;
         // Leave once the last in-flight result is being written this cycle.
         DRAIN:   if (vsr_d == '0) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         bus.busy     <= 1'b0;
         bus.done     <= 1'b0;
         bus.err      <= 1'b0;
         bus.w_addr   <= '0;
         bus.we_rl    <= 1'b0;
         bus.ub_re    <= 1'b0;
         bus.ub_addr  <= '0;
         bus.res_addr <= '0;
         vsr          <= '0;
         wvalid       <= 1'b0;
         rows_left    <= '0;
         res_next     <= '0;
      end else begin
         bus.busy  <= (state_d == WADR) || (state_d == WLD) ||
                      (state_d == STREAM) || (state_d == DRAIN);
         bus.done  <= (state_d == DONE);
         bus.err   <= reject;
         bus.we_rl <= (state_d == WLD);
         bus.ub_re <= (state_d == STREAM);
         vsr       <= vsr_d;

         if (state == WLD) wvalid <= 1'b1;

         if (accept) begin
            rows_left   <= bus.cfg_rows;
            bus.ub_addr <= bus.cfg_ub_base;
            res_next    <= bus.cfg_res_base;
            if (!bus.cfg_wreuse) bus.w_addr <= bus.cfg_wsel;
         end else if (state == STREAM) begin
            rows_left   <= rows_left - RW'(1);
            bus.ub_addr <= bus.ub_addr + ADDRESSSIZE'(1);
         end

         // Address is presented together with the write strobe, held otherwise.
         if (vsr_d[RESULT_LAT-1]) begin
            bus.res_addr <= res_next;
            res_next     <= res_next + ADDRESSSIZE'(1);
         end
      end
   end

endmodule

// File: tb/tb_tpu_tile_sequencer.sv
// Self-checking bench for tpu_tile_sequencer: directed and random passes
// compared cycle by cycle against a timeline-based pass model.
module tb_tpu_tile_sequencer;

   localparam int unsigned AW    = 10;
   localparam int unsigned RW    = AW + 1;
   localparam int unsigned WB    = 2;
   localparam int unsigned MS    = 4;
   localparam int          L     = 11;
   localparam int          AMASK = (1 << AW) - 1;

   logic clk = 1'b0;
   logic rstn;
   always #5 clk = ~clk;

   tpu_tile_sequencer_if #(.ADDRESSSIZE(AW), .WADDR_BW(WB)) bus ();

   tpu_tile_sequencer #(
      .MATRIX_SIZE(MS), .ADDRESSSIZE(AW), .WADDR_BW(WB), .RESULT_LAT(L)
   ) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus.slave)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Pass model: one accepted pass described by its start cycle and config.
   bit m_active = 1'b0;
   int m_t0 = 0, m_rows = 0, m_ub = 0, m_res = 0, m_shift = 0;
   bit m_wvalid = 1'b0;
   int m_wsel = 0;
   int err_cyc = -10;
   int cnt_ub = 0, cnt_res = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   function automatic bit m_idle(input int c);
      return !m_active || (c - m_t0) >= L + m_rows + 4 - m_shift;
   endfunction

   task automatic check_zero(input string tag);
      chk({tag, "_busy"},     32'(bus.busy),     32'd0);
      chk({tag, "_done"},     32'(bus.done),     32'd0);
      chk({tag, "_err"},      32'(bus.err),      32'd0);
      chk({tag, "_w_addr"},   32'(bus.w_addr),   32'd0);
      chk({tag, "_we_rl"},    32'(bus.we_rl),    32'd0);
      chk({tag, "_ub_re"},    32'(bus.ub_re),    32'd0);
      chk({tag, "_ub_addr"},  32'(bus.ub_addr),  32'd0);
      chk({tag, "_res_we"},   32'(bus.res_we),   32'd0);
      chk({tag, "_res_addr"}, 32'(bus.res_addr), 32'd0);
   endtask

   task automatic check_outputs();
      int d = 0;
      bit e_busy = 0, e_done = 0, e_we = 0, e_ub = 0, e_res = 0;
      if (m_active) begin
         d      = cyc - m_t0;
         e_busy = (d >= 1) && (d <= L + m_rows + 2 - m_shift);
         e_done = (d == L + m_rows + 3 - m_shift);
         e_we   = (m_shift == 0) && (d == 2);
         e_ub   = (d >= 3 - m_shift) && (d <= m_rows + 2 - m_shift);
         e_res  = (d >= L + 3 - m_shift) && (d <= L + m_rows + 2 - m_shift);
      end
      chk("busy",   32'(bus.busy),   32'(e_busy));
      chk("done",   32'(bus.done),   32'(e_done));
      chk("we_rl",  32'(bus.we_rl),  32'(e_we));
      chk("ub_re",  32'(bus.ub_re),  32'(e_ub));
      chk("res_we", 32'(bus.res_we), 32'(e_res));
      chk("err",    32'(bus.err),    32'(cyc == err_cyc));
      chk("w_addr", 32'(bus.w_addr), 32'(m_wsel));
      if (e_ub)  chk("ub_addr",  32'(bus.ub_addr),  32'((m_ub + d - (3 - m_shift)) & AMASK));
      if (e_res) chk("res_addr", 32'(bus.res_addr), 32'((m_res + d - (L + 3 - m_shift)) & AMASK));
      cnt_ub  += int'(bus.ub_re);
      cnt_res += int'(bus.res_we);
      if (m_active && m_shift == 0 && d == 2) m_wvalid = 1'b1;
   endtask

   // One clock cycle: check outputs, drive inputs, let the model sample start.
   task automatic step(input bit st, input logic [AW-1:0] ub, input logic [AW-1:0] res,
                       input logic [RW-1:0] rows, input logic [WB-1:0] ws, input bit reuse);
      @(negedge clk);
      check_outputs();
      bus.start        = st;
      bus.cfg_ub_base  = ub;
      bus.cfg_res_base = res;
      bus.cfg_rows     = rows;
      bus.cfg_wsel     = ws;
      bus.cfg_wreuse   = reuse;
      if (st && m_idle(cyc)) begin
         if (rows != '0 && !(reuse && !m_wvalid)) begin
            m_active = 1'b1;
            m_t0     = cyc;
            m_rows   = int'(rows);
            m_ub     = int'(ub);
            m_res    = int'(res);
            m_shift  = reuse ? 2 : 0;
            if (!reuse) m_wsel = int'(ws);
         end else begin
            err_cyc = cyc + 1;
         end
      end
      cyc++;
   endtask

   task automatic rnd_step(input bit st, input int lo, input int hi);
      step(st, AW'($urandom), AW'($urandom), RW'($urandom_range(hi, lo)),
           WB'($urandom), 1'($urandom));
   endtask

   task automatic idle(input int n);
      repeat (n) rnd_step(1'b0, 0, 1024);
   endtask

   task automatic reset_pulse();
      @(negedge clk);
      bus.start = 1'b0;
      rstn = 1'b0;
      #1;
      check_zero("async_rst");
      #1;
      rstn = 1'b1;
      m_active = 1'b0;
      m_wvalid = 1'b0;
      m_wsel   = 0;
      err_cyc  = -10;
      cyc++;
   endtask

   initial begin
      rstn = 1'b0;
      bus.start = 1'b0;
      bus.cfg_ub_base = '0;
      bus.cfg_res_base = '0;
      bus.cfg_rows = '0;
      bus.cfg_wsel = '0;
      bus.cfg_wreuse = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_zero("reset");
      rstn = 1'b1;

      // Reuse before any weights were loaded is rejected.
      step(1'b1, 10'h000, 10'h000, 11'd1, 2'd0, 1'b1);
      idle(4);

      // Basic pass with weight load.
      cnt_ub = 0; cnt_res = 0;
      step(1'b1, 10'h010, 10'h200, 11'd5, 2'd2, 1'b0);
      idle(22);
      chk("p1_ub_count", 32'(cnt_ub), 32'd5);
      chk("p1_res_count", 32'(cnt_res), 32'd5);

      // Reuse pass, single row.
      cnt_ub = 0; cnt_res = 0;
      step(1'b1, 10'h123, 10'h045, 11'd1, 2'd1, 1'b1);
      idle(16);
      chk("reuse_res_count", 32'(cnt_res), 32'(cnt_ub));

      // Zero rows rejected.
      cnt_ub = 0; cnt_res = 0;
      step(1'b1, 10'h001, 10'h002, 11'd0, 2'd3, 1'b0);
      idle(4);
      chk("rows0_ub_count", 32'(cnt_ub), 32'd0);

      // Full-size pass wrapping the UB address.
      cnt_ub = 0; cnt_res = 0;
      step(1'b1, 10'h3FE, 10'h100, 11'd1024, 2'd1, 1'b0);
      idle(1024 + L + 6);
      chk("full_ub_count", 32'(cnt_ub), 32'd1024);
      chk("full_res_count", 32'(cnt_res), 32'd1024);

      // Start held high with cfg toggling every cycle.
      repeat (80) rnd_step(1'b1, 0, 6);
      idle(L + 12);

      // Reset in the middle of streaming.
      cnt_ub = 0; cnt_res = 0;
      step(1'b1, 10'h050, 10'h060, 11'd8, 2'd3, 1'b0);
      idle(5);
      reset_pulse();
      idle(25);
      chk("abort_ub_count", 32'(cnt_ub), 32'd3);
      chk("abort_res_count", 32'(cnt_res), 32'd0);
      step(1'b1, 10'h000, 10'h000, 11'd2, 2'd0, 1'b1);
      idle(4);

      // Result address wrap.
      cnt_ub = 0; cnt_res = 0;
      step(1'b1, 10'h020, 10'h3FF, 11'd3, 2'd2, 1'b0);
      idle(20);
      chk("wrap_res_count", 32'(cnt_res), 32'(cnt_ub));

      // Random traffic.
      repeat (800) rnd_step(($urandom_range(3, 0) == 0), 0, 20);
      idle(L + 30);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
